// File: rtl/ppu_top.sv
// ppu_top: packet processing unit.
//   Checks framed input packets (header, payload, ones-complement checksum),
//   stores them in a ring buffer, commits good packets and drops bad ones,
//   then replays committed packets on the output one word per cycle with
//   at least one idle cycle between packets. An async CPU bus gives access to
//   an enable bit and saturating good/bad packet counters.
// Ports:
//   clk_100m, rst_n         system clock, async active-low reset
//   scan_en, test_mode      DFT only, no functional use
//   CPU_CS_N/RD_N/WE_N      async CPU strobes (active-low)
//   CPU_ADDR, CPU_DATA      CPU byte address, bidirectional data
//   CPU_RDY_N               access-complete, active-low
//   vid_in, data_in         input packet valid / word
//   vid_out, data_out       output packet valid / word (zero when idle)
module ppu_top #(
  parameter int BUF_DEPTH   = 1024,
  parameter int MAX_PAYLOAD = 1000
) (
  input  logic        clk_100m,
  input  logic        rst_n,
  input  logic        scan_en,
  input  logic        test_mode,
  input  logic        CPU_CS_N,
  input  logic        CPU_RD_N,
  input  logic        CPU_WE_N,
  input  logic [15:0] CPU_ADDR,
  inout  wire  [31:0] CPU_DATA,
  output logic        CPU_RDY_N,
  input  logic        vid_in,
  input  logic [15:0] data_in,
  output logic        vid_out,
  output logic [15:0] data_out
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(MAX_PAYLOAD + 3);
  typedef logic [PW-1:0] ptr_t;

  function automatic ptr_t inc(input ptr_t p);
    return (p == ptr_t'(BUF_DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  // Ones-complement add with end-around carry.
  function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'b0, s[16]};
  endfunction

  // Buffer word: {6'b0, first, last, data}
  logic [23:0] mem [BUF_DEPTH];
  logic        mem_we;
  ptr_t        mem_wa;
  logic [23:0] mem_wd;
  logic [23:0] rd_word;

  ptr_t          wr_ptr_q, cmt_ptr_q, rd_ptr_q, last_q;
  logic          vid_prev_q, in_pkt_q, hdr_ok_q, drop_q, gap_q;
  logic [CW-1:0] cnt_q;     // words received after the header
  logic [15:0]   sum_q;     // payload sum excluding the newest word
  logic [15:0]   prev_q;    // newest word; becomes the checksum at the end
  logic          vid_out_q;
  logic [15:0]   data_out_q;

  logic rise, start, word, fall, full, too_long, pkt_ok, acc_hdr, acc_word;
  logic [15:0] exp_ck;

  // CPU side
  logic [1:0]  cs_sq, rd_sq, we_sq;
  logic        cs_act, rd_act, we_act, strobe, do_wr;
  logic        seen_q, we_done_q, rdy_n_q, en_q;
  logic [31:0] ok_cnt_q, err_cnt_q, rdata_d, rdata_q;

  always_comb begin
    rise     = vid_in & ~vid_prev_q;
    start    = rise & en_q;
    word     = in_pkt_q & vid_in;
    fall     = in_pkt_q & ~vid_in;
    full     = (inc(wr_ptr_q) == rd_ptr_q);
    too_long = (cnt_q == CW'(MAX_PAYLOAD + 1));
    exp_ck   = (sum_q == 16'hFFFF) ? 16'hFFFF : ~sum_q;
    pkt_ok   = ~drop_q & hdr_ok_q & (cnt_q >= CW'(2)) & (prev_q == exp_ck);
    acc_hdr  = start & ~full;
    acc_word = word & ~drop_q & ~full & ~too_long;
    mem_we   = 1'b0;
    mem_wa   = wr_ptr_q;
    mem_wd   = {6'b0, 2'b00, data_in};
    if (acc_hdr) begin
      mem_we = 1'b1;
      mem_wd = {6'b0, 2'b10, data_in};
    end else if (acc_word) begin
      mem_we = 1'b1;
    end else if (fall & pkt_ok) begin
      // last flag is only known once vid_in drops: rewrite the checksum word
      mem_we = 1'b1;
      mem_wa = last_q;
      mem_wd = {6'b0, 2'b01, prev_q};
    end
  end

  always_ff @(posedge clk_100m) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  // Input side: parse, store, commit or discard
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      vid_prev_q <= 1'b1;   // a packet already running at release is ignored
      in_pkt_q   <= 1'b0;
      hdr_ok_q   <= 1'b0;
      drop_q     <= 1'b0;
      cnt_q      <= '0;
      sum_q      <= '0;
      prev_q     <= '0;
      wr_ptr_q   <= '0;
      cmt_ptr_q  <= '0;
      last_q     <= '0;
    end else begin
      vid_prev_q <= vid_in;
      if (start) begin
        in_pkt_q <= 1'b1;
        hdr_ok_q <= (data_in == 16'h55D4) || (data_in == 16'h55D5);
        drop_q   <= full;
        cnt_q    <= '0;
        sum_q    <= '0;
        prev_q   <= '0;
        if (!full) begin
          wr_ptr_q <= inc(wr_ptr_q);
          last_q   <= wr_ptr_q;
        end
      end else if (word) begin
        if (acc_word) begin
          wr_ptr_q <= inc(wr_ptr_q);
          last_q   <= wr_ptr_q;
          cnt_q    <= cnt_q + CW'(1);
          prev_q   <= data_in;
          if (cnt_q != '0) sum_q <= oc_add(sum_q, prev_q);
        end else begin
          drop_q <= 1'b1;
        end
      end else if (fall) begin
        in_pkt_q <= 1'b0;
        if (pkt_ok) cmt_ptr_q <= wr_ptr_q;
        else        wr_ptr_q  <= cmt_ptr_q;
      end
    end
  end

  // Output side: stream committed words, idle one cycle after each last word
  assign rd_word = mem[rd_ptr_q];

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q   <= '0;
      gap_q      <= 1'b0;
      vid_out_q  <= 1'b0;
      data_out_q <= '0;
    end else if (gap_q) begin
      gap_q      <= 1'b0;
      vid_out_q  <= 1'b0;
      data_out_q <= '0;
    end else if (rd_ptr_q != cmt_ptr_q) begin
      vid_out_q  <= 1'b1;
      data_out_q <= rd_word[15:0];
      rd_ptr_q   <= inc(rd_ptr_q);
      gap_q      <= rd_word[16];
    end else begin
      vid_out_q  <= 1'b0;
      data_out_q <= '0;
    end
  end

  assign vid_out  = vid_out_q;
  assign data_out = data_out_q;

  // CPU bus: two-flop strobe sync, one write per WE_N pulse, registers
  assign cs_act = ~cs_sq[1];
  assign rd_act = ~rd_sq[1];
  assign we_act = ~we_sq[1];
  assign strobe = cs_act & (rd_act | we_act);
  assign do_wr  = cs_act & we_act & ~we_done_q;

  always_comb begin
    rdata_d = '0;
    case (CPU_ADDR)
      16'h4000: rdata_d = {31'b0, en_q};
      16'h4008: rdata_d = ok_cnt_q;
      16'h400C: rdata_d = err_cnt_q;
      default:  rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      cs_sq     <= 2'b11;
      rd_sq     <= 2'b11;
      we_sq     <= 2'b11;
      seen_q    <= 1'b0;
      we_done_q <= 1'b0;
      rdy_n_q   <= 1'b1;
      en_q      <= 1'b1;
      ok_cnt_q  <= '0;
      err_cnt_q <= '0;
      rdata_q   <= '0;
    end else begin
      cs_sq   <= {cs_sq[0], CPU_CS_N};
      rd_sq   <= {rd_sq[0], CPU_RD_N};
      we_sq   <= {we_sq[0], CPU_WE_N};
      rdata_q <= rdata_d;
      if (!cs_act) begin
        seen_q  <= 1'b0;
        rdy_n_q <= 1'b1;
      end else if (strobe) begin
        seen_q <= 1'b1;
        if (seen_q) rdy_n_q <= 1'b0;
      end
      if (do_wr)                 we_done_q <= 1'b1;
      else if (!(cs_act & we_act)) we_done_q <= 1'b0;
      if (do_wr && CPU_ADDR == 16'h4000) en_q <= CPU_DATA[0];
      if (do_wr && CPU_ADDR == 16'h4004) begin
        ok_cnt_q  <= '0;
        err_cnt_q <= '0;
      end else begin
        if (fall && pkt_ok && ok_cnt_q != 32'hFFFF_FFFF)   ok_cnt_q  <= ok_cnt_q + 32'd1;
        if (fall && !pkt_ok && err_cnt_q != 32'hFFFF_FFFF) err_cnt_q <= err_cnt_q + 32'd1;
      end
    end
  end

  assign CPU_RDY_N = rdy_n_q;
  assign CPU_DATA  = (rst_n & ~CPU_CS_N & ~CPU_RD_N) ? rdata_q : 32'hzzzz_zzzz;

  logic unused_ok;
  assign unused_ok = &{1'b0, scan_en, test_mode, CPU_DATA[31:1], rd_word[23:17]};
endmodule

// File: tb/tb_ppu_top.sv
// Randomized bench for ppu_top with a queue-based packet reference model.
module tb_ppu_top;
  localparam int MAXP = 1000;

  logic        clk_100m = 1'b0;
  logic        rst_n = 1'b1;
  logic        scan_en = 1'b0, test_mode = 1'b0;
  logic        CPU_CS_N = 1'b1, CPU_RD_N = 1'b1, CPU_WE_N = 1'b1;
  logic [15:0] CPU_ADDR = '0;
  wire  [31:0] CPU_DATA;
  logic        CPU_RDY_N;
  logic        vid_in = 1'b0;
  logic [15:0] data_in = '0;
  logic        vid_out;
  logic [15:0] data_out;
  logic [31:0] cpu_wd = '0;
  logic        cpu_drv = 1'b0;

  assign CPU_DATA = cpu_drv ? cpu_wd : 32'hzzzz_zzzz;
  always #5 clk_100m = ~clk_100m;

  ppu_top #(.BUF_DEPTH(1024), .MAX_PAYLOAD(MAXP)) dut (
    .clk_100m(clk_100m), .rst_n(rst_n), .scan_en(scan_en), .test_mode(test_mode),
    .CPU_CS_N(CPU_CS_N), .CPU_RD_N(CPU_RD_N), .CPU_WE_N(CPU_WE_N),
    .CPU_ADDR(CPU_ADDR), .CPU_DATA(CPU_DATA), .CPU_RDY_N(CPU_RDY_N),
    .vid_in(vid_in), .data_in(data_in), .vid_out(vid_out), .data_out(data_out)
  );

  int n_vec = 0, n_err = 0;
  logic [15:0] exp_q[$], got_q[$], pl[$];
  int exp_len[$], got_len[$];
  int cur_len = 0;
  int exp_ok = 0, exp_err = 0;
  bit en_m = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Output monitor: collect words and burst lengths, idle output must be zero
  always @(negedge clk_100m) begin
    if (rst_n) begin
      if (vid_out) begin
        got_q.push_back(data_out);
        cur_len++;
      end else begin
        chk("idle_dout", 32'(data_out), 32'h0);
        if (cur_len > 0) begin
          got_len.push_back(cur_len);
          cur_len = 0;
        end
      end
    end
  end

  function automatic logic [15:0] ocsum();
    int s = 0;
    foreach (pl[i]) begin
      s += int'(pl[i]);
      if (s > 65535) s -= 65535;   // end-around carry
    end
    return 16'(s);
  endfunction

  function automatic logic [15:0] ck_of(input logic [15:0] s);
    return (s == 16'hFFFF) ? 16'hFFFF : ~s;
  endfunction

  task automatic rand_pl(input int n);
    pl.delete();
    repeat (n) pl.push_back(16'($urandom));
  endtask

  task automatic send_pkt(input logic [15:0] hdr, input bit use_ck, input logic [15:0] ck_val, input int gap);
    logic [15:0] s, ck;
    bit ok;
    s  = ocsum();
    ck = use_ck ? ck_val : ck_of(s);
    ok = (hdr == 16'h55D4 || hdr == 16'h55D5) && pl.size() >= 1 && pl.size() <= MAXP && ck == ck_of(s);
    if (en_m) begin
      if (ok) begin
        exp_q.push_back(hdr);
        foreach (pl[i]) exp_q.push_back(pl[i]);
        exp_q.push_back(ck);
        exp_len.push_back(pl.size() + 2);
        exp_ok++;
      end else exp_err++;
    end
    @(negedge clk_100m); vid_in = 1'b1; data_in = hdr;
    foreach (pl[i]) begin @(negedge clk_100m); data_in = pl[i]; end
    @(negedge clk_100m); data_in = ck;
    @(negedge clk_100m); vid_in = 1'b0; data_in = '0;
    repeat (gap - 1) @(negedge clk_100m);
  endtask

  task automatic drain_chk(input string tag);
    int t = 0;
    while ((got_q.size() < exp_q.size() || vid_out) && t < 5000) begin
      @(negedge clk_100m); t++;
    end
    repeat (8) @(negedge clk_100m);
    chk({tag, "_nwords"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0)
      chk({tag, "_word"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    chk({tag, "_nbursts"}, 32'(got_len.size()), 32'(exp_len.size()));
    while (exp_len.size() > 0 && got_len.size() > 0)
      chk({tag, "_blen"}, 32'(got_len.pop_front()), 32'(exp_len.pop_front()));
    exp_q.delete(); got_q.delete(); exp_len.delete(); got_len.delete();
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [31:0] d);
    int t;
    @(negedge clk_100m);
    CPU_ADDR = a; cpu_wd = d; cpu_drv = 1'b1; CPU_CS_N = 1'b0; CPU_WE_N = 1'b0;
    t = 0;
    while (CPU_RDY_N && t < 20) begin @(negedge clk_100m); t++; end
    chk("wr_rdy", 32'(CPU_RDY_N), 32'h0);
    @(negedge clk_100m); CPU_WE_N = 1'b1; CPU_CS_N = 1'b1; cpu_drv = 1'b0;
    t = 0;
    while (!CPU_RDY_N && t < 20) begin @(negedge clk_100m); t++; end
    chk("wr_rdy_off", 32'(CPU_RDY_N), 32'h1);
    repeat (3) @(negedge clk_100m);
  endtask

  task automatic cpu_rd(input logic [15:0] a, output logic [31:0] d);
    int t;
    @(negedge clk_100m);
    CPU_ADDR = a; CPU_CS_N = 1'b0; CPU_RD_N = 1'b0;
    t = 0;
    while (CPU_RDY_N && t < 20) begin @(negedge clk_100m); t++; end
    chk("rd_rdy", 32'(CPU_RDY_N), 32'h0);
    @(negedge clk_100m); d = CPU_DATA;
    CPU_RD_N = 1'b1; CPU_CS_N = 1'b1;
    t = 0;
    while (!CPU_RDY_N && t < 20) begin @(negedge clk_100m); t++; end
    repeat (3) @(negedge clk_100m);
  endtask

  task automatic reg_chk(input string tag, input logic [15:0] a, input logic [31:0] exp);
    logic [31:0] d;
    cpu_rd(a, d);
    chk(tag, d, exp);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] s;
    logic [15:0] hdr;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_vid_out", 32'(vid_out), 32'h0);
    chk("rst_data_out", 32'(data_out), 32'h0);
    chk("rst_rdy_n", 32'(CPU_RDY_N), 32'h1);
    repeat (3) @(negedge clk_100m);
    rst_n = 1'b1;
    repeat (5) @(negedge clk_100m);

    reg_chk("ctrl_rst", 16'h4000, 32'h1);
    reg_chk("rxok_rst", 16'h4008, 32'h0);
    reg_chk("rxerr_rst", 16'h400C, 32'h0);
    reg_chk("unmapped_rd", 16'h4010, 32'h0);
    cpu_wr(16'h4010, 32'h0);
    cpu_wr(16'h0000, 32'h0);
    reg_chk("ctrl_after_unmapped_wr", 16'h4000, 32'h1);

    // 560-word payload
    rand_pl(560); send_pkt(16'h55D5, 1'b0, 16'h0, 4);
    drain_chk("p560");
    reg_chk("rxok_p560", 16'h4008, 32'(exp_ok));

    // checksum off by one
    rand_pl(30); s = ocsum();
    send_pkt(16'h55D4, 1'b1, 16'(ck_of(s) + 16'd1), 4);
    drain_chk("badck");
    reg_chk("rxerr_badck", 16'h400C, 32'(exp_err));

    // one-word and 622-word payloads
    pl.delete(); pl.push_back(16'h1234);
    send_pkt(16'h55D5, 1'b1, 16'hEDCB, 4);
    rand_pl(622); send_pkt(16'h55D4, 1'b0, 16'h0, 4);
    drain_chk("p1_p622");

    // payload sum of 0xFFFF: only checksum 0xFFFF is accepted
    pl.delete(); pl.push_back(16'h1234); pl.push_back(16'hEDCB);
    send_pkt(16'h55D5, 1'b1, 16'hFFFF, 4);
    send_pkt(16'h55D5, 1'b1, 16'h0000, 4);
    drain_chk("sumffff");

    // bad header, empty payload, max payload, over max payload
    rand_pl(5); send_pkt(16'h55D6, 1'b0, 16'h0, 4);
    pl.delete(); send_pkt(16'h55D4, 1'b0, 16'h0, 4);
    rand_pl(MAXP); send_pkt(16'h55D5, 1'b0, 16'h0, 4);
    drain_chk("bounds_a");
    rand_pl(MAXP + 1); send_pkt(16'h55D4, 1'b0, 16'h0, 4);
    drain_chk("bounds_b");
    reg_chk("rxok_bounds", 16'h4008, 32'(exp_ok));
    reg_chk("rxerr_bounds", 16'h400C, 32'(exp_err));

    // clear counters, then ten back-to-back packets with one bad checksum
    cpu_wr(16'h4004, 32'h0);
    exp_ok = 0; exp_err = 0;
    reg_chk("rxok_clr", 16'h4008, 32'h0);
    reg_chk("rxerr_clr", 16'h400C, 32'h0);
    for (int i = 0; i < 10; i++) begin
      rand_pl($urandom_range(1, 40));
      hdr = ($urandom_range(0, 1) != 0) ? 16'h55D5 : 16'h55D4;
      s = ocsum();
      if (i == 6) send_pkt(hdr, 1'b1, 16'(ck_of(s) + 16'd1), 4);
      else        send_pkt(hdr, 1'b0, 16'h0, 4);
    end
    drain_chk("ten");
    reg_chk("rxok_ten", 16'h4008, 32'(exp_ok));
    reg_chk("rxerr_ten", 16'h400C, 32'(exp_err));

    // disabled: good packet is not accepted
    cpu_wr(16'h4000, 32'h0);
    en_m = 1'b0;
    reg_chk("ctrl_off", 16'h4000, 32'h0);
    rand_pl(20); send_pkt(16'h55D5, 1'b0, 16'h0, 4);
    drain_chk("disabled");
    reg_chk("rxok_disabled", 16'h4008, 32'(exp_ok));
    cpu_wr(16'h4000, 32'h1);
    en_m = 1'b1;
    rand_pl(12); send_pkt(16'h55D4, 1'b0, 16'h0, 4);
    drain_chk("reenabled");

    // reset mid-packet while the previous packet is still streaming out
    rand_pl(300); send_pkt(16'h55D5, 1'b0, 16'h0, 4);
    @(negedge clk_100m); vid_in = 1'b1; data_in = 16'h55D4;
    repeat (20) begin @(negedge clk_100m); data_in = 16'($urandom); end
    @(posedge clk_100m); #2 rst_n = 1'b0;
    #1;
    chk("rstmid_vid_out", 32'(vid_out), 32'h0);
    chk("rstmid_data_out", 32'(data_out), 32'h0);
    chk("rstmid_rdy_n", 32'(CPU_RDY_N), 32'h1);
    exp_q.delete(); got_q.delete(); exp_len.delete(); got_len.delete();
    cur_len = 0; exp_ok = 0; exp_err = 0;
    repeat (3) @(negedge clk_100m);
    data_in = 16'h55D5;
    @(posedge clk_100m); #2 rst_n = 1'b1;
    // tail of a packet already running at release must be ignored
    @(negedge clk_100m); data_in = 16'h1234;
    @(negedge clk_100m); data_in = 16'hEDCB;
    @(negedge clk_100m); vid_in = 1'b0; data_in = '0;
    repeat (6) @(negedge clk_100m);
    drain_chk("ghost");
    rand_pl(10); send_pkt(16'h55D5, 1'b0, 16'h0, 4);
    drain_chk("after_rst");
    reg_chk("rxok_after_rst", 16'h4008, 32'(exp_ok));
    reg_chk("rxerr_after_rst", 16'h400C, 32'(exp_err));
    reg_chk("ctrl_after_rst", 16'h4000, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
